dft_hijack_ctrl: RTL

Test-side controller that drives the `ten_hijack` / `ten_hijacki` pairs of the DFT hijack cells placed on analog-control nets such as the stepdown regulation clock. It decodes 16-bit serial frames from the test port and gates all hijack control behind a two-frame unlock key. It drives per-channel enable and forced value, and reads the hijacked nets back through a serial return path. It sits in the DFT island beside the hijack cells it controls.

---
 rtl/dft_hijack_pkg.sv | 18 +
 rtl/dft_hijack_shifter.sv | 34 +++
 rtl/dft_hijack_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/dft_hijack_pkg.sv
// dft_hijack_pkg: shared FSM state and opcode enums plus frame geometry for the DFT hijack controller
package dft_hijack_pkg;
  localparam int HJ_FRAME_W = 16;
  localparam int HJ_OP_W = 4;
  typedef enum logic [1:0] {
    HJ_LOCKED   = 2'd0,
    HJ_UNLOCK1  = 2'd1,
    HJ_UNLOCKED = 2'd2
  } hj_state_t;
  typedef enum logic [HJ_OP_W-1:0] {
    OP_UNLOCK  = 4'h1,
    OP_WR_EN   = 4'h2,
    OP_WR_VAL  = 4'h3,
    OP_READ    = 4'h4,
    OP_LOCK    = 4'h5,
    OP_CLR_ERR = 4'h6
  } hj_op_t;
endpackage

// File: rtl/dft_hijack_shifter.sv
// dft_hijack_shifter: frame shift-in (tsel/tdi), saturating bit count, frame-end detect (frame_end, len_ok) and return shift-out (load_rd/rd_data -> tdo)
module dft_hijack_shifter
  import dft_hijack_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tsel,
  input  logic                  tdi,
  input  logic                  load_rd,
  input  logic [HJ_FRAME_W-1:0] rd_data,
  output logic [HJ_FRAME_W-1:0] frame,
  output logic                  frame_end,
  output logic                  len_ok,
  output logic                  tdo
);
  logic                  tsel_q;
  logic [4:0]            cnt;
  logic [HJ_FRAME_W-1:0] ret;
  assign frame_end = tsel_q & ~tsel;
  assign len_ok = cnt == 5'd16;
  assign tdo = ret[HJ_FRAME_W-1];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tsel_q <= 1'b0;
      cnt <= 5'd0;
      frame <= '0;
      ret <= '0;
    end else begin
      tsel_q <= tsel;
      if (tsel) frame <= {frame[HJ_FRAME_W-2:0], tdi};
      cnt <= frame_end ? 5'd0 : (tsel && cnt != 5'd17) ? cnt + 5'd1 : cnt;
      ret <= load_rd ? rd_data : tsel ? {ret[HJ_FRAME_W-2:0], 1'b0} : ret;
    end
endmodule

// File: rtl/dft_hijack_ctrl.sv
// dft_hijack_ctrl: key-gated serial controller (tsel/tdi in, tdo out) driving ten_hijack/ten_hijacki[NCH], reading hj_obs, flags unlocked/err; optional idle relock with DFT_HIJACK_TIMEOUT_EN
module dft_hijack_ctrl
  import dft_hijack_pkg::*;
#(
  parameter int          NCH     = 4,
  parameter logic [11:0] KEY1    = 12'hA5C,
  parameter logic [11:0] KEY2    = 12'h3E7,
  parameter int          TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           CELV,
  input  logic           CELG,
  input  logic           CELSUB,
  input  logic           tsel,
  input  logic           tdi,
  output logic           tdo,
  output logic [NCH-1:0] ten_hijack,
  output logic [NCH-1:0] ten_hijacki,
  input  logic [NCH-1:0] hj_obs,
  output logic           unlocked,
  output logic           err
);
  hj_state_t             state, st_n;
  logic [NCH-1:0]        en_n, val_n;
  logic                  err_n, rd_load, to_hit, frame_end, len_ok, unused;
  logic [HJ_FRAME_W-1:0] frame, rd_data;
  logic [HJ_OP_W-1:0]    op;
  logic [11:0]           pl;
  assign op = frame[HJ_FRAME_W-1 -: HJ_OP_W];
  assign pl = frame[11:0];
  assign rd_load = frame_end & len_ok & (op == OP_READ);
  assign rd_data = {state, err, 1'b0, 12'(hj_obs)};
  assign unused = ^{CELV, CELG, CELSUB, frame, TIMEOUT != 0};
  dft_hijack_shifter u_shifter (
    .clk(clk), .rst(rst), .tsel(tsel), .tdi(tdi), .load_rd(rd_load), .rd_data(rd_data),
    .frame(frame), .frame_end(frame_end), .len_ok(len_ok), .tdo(tdo)
  );
`ifdef DFT_HIJACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  assign to_hit = state == HJ_UNLOCKED && !tsel && tcnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) tcnt <= '0;
    else tcnt <= (state != HJ_UNLOCKED || tsel || to_hit) ? '0 : tcnt + TW'(1);
`else
  assign to_hit = 1'b0;
`endif
  always_comb begin
    st_n = state;
    en_n = ten_hijack;
    val_n = ten_hijacki;
    err_n = err;
    if (frame_end && !len_ok) begin
      err_n = 1'b1;
      if (state == HJ_UNLOCK1) st_n = HJ_LOCKED;
    end
    if (frame_end && len_ok) begin
      if (op != OP_UNLOCK && state == HJ_UNLOCK1) st_n = HJ_LOCKED;
      case (op)
        OP_UNLOCK: begin
          if (state == HJ_LOCKED) begin
            st_n = pl == KEY1 ? HJ_UNLOCK1 : HJ_LOCKED;
            err_n = err | (pl != KEY1);
          end else if (state == HJ_UNLOCK1) begin
            st_n = pl == KEY2 ? HJ_UNLOCKED : HJ_LOCKED;
            err_n = err | (pl != KEY2);
          end
        end
        OP_WR_EN:   if (state == HJ_UNLOCKED) en_n = pl[NCH-1:0];
        OP_WR_VAL:  if (state == HJ_UNLOCKED) val_n = pl[NCH-1:0];
        OP_LOCK:    st_n = HJ_LOCKED;
        OP_CLR_ERR: err_n = 1'b0;
        default: ;
      endcase
    end
    if (to_hit) st_n = HJ_LOCKED;
    if (st_n != HJ_UNLOCKED) begin
      en_n = '0;
      val_n = '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= HJ_LOCKED;
      ten_hijack <= '0;
      ten_hijacki <= '0;
      err <= 1'b0;
      unlocked <= 1'b0;
    end else begin
      state <= st_n;
      ten_hijack <= en_n;
      ten_hijacki <= val_n;
      err <= err_n;
      unlocked <= st_n == HJ_UNLOCKED;
    end
endmodule
